// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
// RV32I instruction fetch: credit-limited imem requests, response FIFO, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises misalign_fault and halts fetch.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   LIM  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_tq_wp;
  logic [AW-1:0] r_tq_rp;
  logic [31:0]   r_data [FIFO_DEPTH];
  logic [31:0]   r_ipc  [FIFO_DEPTH];
  logic [31:0]   r_tq   [FIFO_DEPTH];

  logic          w_fault;
  logic [CW:0]   w_used;
  logic          w_req_valid;
  logic          w_req_hs;
  logic          w_rsp;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_inst_valid;
  logic          w_pop;
  logic [CW-1:0] w_out_nxt;
  logic [31:0]   w_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;
  logic w_mis;
  assign w_mis          = redirect_pc[1:0] != 2'b00;
  assign w_fault        = r_fault;
  assign misalign_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign w_tgt        = redirect_pc & 32'hFFFF_FFFC;
  assign w_used       = {1'b0, r_out} + {1'b0, r_cnt};
  assign w_req_valid  = reset_n && !w_fault && (w_used < LIM);
  assign w_req_hs     = w_req_valid && imem_req_ready;
  assign w_rsp        = imem_rsp_valid && (r_out != '0);
  assign w_rsp_drop   = w_rsp && (r_drop != '0);
  assign w_push       = w_rsp && !w_rsp_drop && !redirect_valid;
  assign w_inst_valid = r_cnt != '0;
  assign w_pop        = w_inst_valid && inst_ready;
  assign w_out_nxt    = r_out + CW'(w_req_hs) - CW'(w_rsp);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = w_inst_valid;
  assign inst           = w_inst_valid ? r_data[r_rp] : '0;
  assign inst_pc        = w_inst_valid ? r_ipc[r_rp] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_drop  <= '0;
      r_cnt   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_tq_wp <= '0;
      r_tq_rp <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_fault <= 1'b0;
`endif
    end else begin
      r_out <= w_out_nxt;
      if (redirect_valid) begin
        // everything still in flight belongs to the old stream
        r_pc    <= w_tgt;
        r_drop  <= w_out_nxt;
        r_cnt   <= '0;
        r_wp    <= '0;
        r_rp    <= '0;
        r_tq_wp <= '0;
        r_tq_rp <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        r_fault <= w_mis;
`endif
      end else begin
        if (w_req_hs) begin
          r_pc    <= r_pc + 32'd4;
          r_tq_wp <= r_tq_wp + AW'(1);
        end
        if (w_rsp_drop)
          r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_wp    <= r_wp + AW'(1);
          r_tq_rp <= r_tq_rp + AW'(1);
        end
        if (w_pop)
          r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs)
      r_tq[r_tq_wp] <= r_pc;
    if (w_push) begin
      r_data[r_wp] <= imem_rsp_data;
      r_ipc[r_wp]  <= r_tq[r_tq_rp];
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(w_push && (r_cnt == FULL)));

endmodule
